// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: opcode constants, hazard-unit state
// encoding and the stage-2 operand-use decode.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        FWD  = 2'd2
    } hz_state_t;

    // LUI/AUIPC/JAL carry no rs1 field; anything else may read rs1.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/load_hazard_unit_if.sv
// Pipeline-facing signal bundle of the load hazard unit. The pipeline drives
// through the master modport; the hazard unit sits on the slave modport.
interface load_hazard_unit_if #(
    parameter int XLEN = 32
);
    logic [6:0]      OPCODE_STAGE2;
    logic [6:0]      OPCODE_STAGE3;
    logic [4:0]      RADDR1_STAGE2;
    logic [4:0]      RADDR2_STAGE2;
    logic [4:0]      wr_addr_STAGE3;
    logic            WR_EN_STAGE3;
    logic            FLUSH;
    logic            MEM_RVALID;
    logic [XLEN-1:0] MEM_RDATA;
    logic [XLEN-1:0] RS1_IN;
    logic [XLEN-1:0] RS2_IN;
    logic [XLEN-1:0] RS1_OUT;
    logic [XLEN-1:0] RS2_OUT;
    logic            STALL;
    logic            BUBBLE;
    logic            MEM_TIMEOUT;

    modport master (
        output OPCODE_STAGE2, OPCODE_STAGE3, RADDR1_STAGE2, RADDR2_STAGE2,
               wr_addr_STAGE3, WR_EN_STAGE3, FLUSH, MEM_RVALID, MEM_RDATA,
               RS1_IN, RS2_IN,
        input  RS1_OUT, RS2_OUT, STALL, BUBBLE, MEM_TIMEOUT
    );

    modport slave (
        input  OPCODE_STAGE2, OPCODE_STAGE3, RADDR1_STAGE2, RADDR2_STAGE2,
               wr_addr_STAGE3, WR_EN_STAGE3, FLUSH, MEM_RVALID, MEM_RDATA,
               RS1_IN, RS2_IN,
        output RS1_OUT, RS2_OUT, STALL, BUBBLE, MEM_TIMEOUT
    );
endinterface

// File: rtl/load_hazard_unit.sv
// Load-use hazard unit: stalls stages 1-2 behind a load in stage 3, waits for
// the data-memory response and forwards it to the consumer for one cycle.
module load_hazard_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int XLEN           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    load_hazard_unit_if.slave hz
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    hz_state_t       state_q,    state_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [4:0]      pend_rd_q,  pend_rd_d;
    logic [XLEN-1:0] load_buf_q, load_buf_d;
    logic            timeout_q,  timeout_d;

    logic            hazard_s;
    logic            stall_s;
    logic            bubble_s;
    logic [XLEN-1:0] rs1_s;
    logic [XLEN-1:0] rs2_s;

    // A flushed stage-2 instruction never needs protecting, and x0 is never a producer.
    assign hazard_s = (state_q == RUN)
                   && (hz.OPCODE_STAGE3 == OP_LOAD)
                   && hz.WR_EN_STAGE3
                   && (hz.wr_addr_STAGE3 != 5'd0)
                   && ((uses_rs1(hz.OPCODE_STAGE2) && (hz.wr_addr_STAGE3 == hz.RADDR1_STAGE2))
                    || (uses_rs2(hz.OPCODE_STAGE2) && (hz.wr_addr_STAGE3 == hz.RADDR2_STAGE2)))
                   && !hz.FLUSH;

    // Next-state and pipeline-control decode.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pend_rd_d  = pend_rd_q;
        load_buf_d = load_buf_q;
        timeout_d  = timeout_q;
        stall_s    = 1'b0;
        bubble_s   = 1'b0;
        rs1_s      = hz.RS1_IN;
        rs2_s      = hz.RS2_IN;
        case (state_q)
            RUN: begin
                if (hazard_s) begin
                    stall_s   = 1'b1;
                    bubble_s  = 1'b1;
                    pend_rd_d = hz.wr_addr_STAGE3;
                    count_d   = {CNT_W{1'b0}};
                    state_d   = WAIT;
                end else begin
                    state_d   = RUN;
                end
            end
            WAIT: begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
                if (hz.FLUSH) begin
                    stall_s = 1'b0;
                    state_d = RUN;
                end else if (hz.MEM_RVALID) begin
                    load_buf_d = hz.MEM_RDATA;
                    state_d    = FWD;
                end else if (count_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = RUN;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            FWD: begin
                if (hz.RADDR1_STAGE2 == pend_rd_q) begin
                    rs1_s = load_buf_q;
                end else begin
                    rs1_s = hz.RS1_IN;
                end
                if (hz.RADDR2_STAGE2 == pend_rd_q) begin
                    rs2_s = load_buf_q;
                end else begin
                    rs2_s = hz.RS2_IN;
                end
                bubble_s = hz.FLUSH;
                state_d  = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, pending-load and sticky-error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            count_q    <= {CNT_W{1'b0}};
            pend_rd_q  <= 5'd0;
            load_buf_q <= {XLEN{1'b0}};
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pend_rd_q  <= pend_rd_d;
            load_buf_q <= load_buf_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hz.STALL       = stall_s;
    assign hz.BUBBLE      = bubble_s;
    assign hz.RS1_OUT     = rs1_s;
    assign hz.RS2_OUT     = rs2_s;
    assign hz.MEM_TIMEOUT = timeout_q;

endmodule

// File: doc/load_hazard_unit.md
Name: load_hazard_unit

Overview:
- Companion to the stage-2 ALU-result forwarding path. Handles the producer cases that path cannot cover: loads in stage 3 whose data returns later from data memory.
- Detects a load-use hazard between stage 3 and stage 2, and stalls stages 1-2 while injecting bubbles into stage 3.
- Captures the returning load data and forwards it to the stalled consumer for exactly one cycle.
- Sits between the forwarding mux outputs and the stage-2/3 pipeline register.

Parameters:
TIMEOUT_CYCLES, 64, max WAIT cycles before abandoning a load wait; must be >= 1
XLEN, 32, data width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
OPCODE_STAGE2  in  7  opcode of the instruction in register-read stage
OPCODE_STAGE3  in  7  opcode of the instruction in execute stage
RADDR1_STAGE2  in  5  rs1 of stage 2
RADDR2_STAGE2  in  5  rs2 of stage 2
wr_addr_STAGE3  in  5  rd of stage 3
WR_EN_STAGE3  in  1  stage-3 register write enable
FLUSH  in  1  branch/jump redirect; kills stages 1-2
MEM_RVALID  in  1  data-memory read response valid
MEM_RDATA  in  XLEN  data-memory read response data
RS1_IN  in  XLEN  rs1 value after ALU forwarding
RS2_IN  in  XLEN  rs2 value after ALU forwarding
RS1_OUT  out  XLEN  rs1 value into stage-2/3 register
RS2_OUT  out  XLEN  rs2 value into stage-2/3 register
STALL  out  1  hold PC and stage-1/2 registers
BUBBLE  out  1  load NOP into stage-2/3 register
MEM_TIMEOUT  out  1  sticky error: wait exceeded TIMEOUT_CYCLES

Behaviour:
- Single clock clk. Reset is asynchronous, active-low on rst_n. Reset gives: state=RUN, count=0, pend_rd=0, load_buf=0, MEM_TIMEOUT=0.
- Combinational outputs:
  - STALL and BUBBLE are 0 in RUN without a hazard.
  - RS1_OUT=RS1_IN and RS2_OUT=RS2_IN except in FWD.
- Operand-use decode on OPCODE_STAGE2:
  - uses_rs1 = not one of LUI 0110111, AUIPC 0010111, JAL 1101111.
  - uses_rs2 = one of 0110011, 0100011 (store), 1100011 (branch).
- Hazard H is evaluated in RUN only:
  - H = (OPCODE_STAGE3==0000011) & WR_EN_STAGE3 & (wr_addr_STAGE3!=0) & ((uses_rs1 & rd==RADDR1) | (uses_rs2 & rd==RADDR2)) & !FLUSH.
- States:
  - RUN:
    - If H: STALL=1 and BUBBLE=1 this cycle. Latch pend_rd=wr_addr_STAGE3 and count=0. Go to WAIT.
    - A MEM_RVALID in this same cycle is ignored, because it belongs to an older load.
  - WAIT: STALL=1, BUBBLE=1. Evaluated in priority order:
    - FLUSH=1 -> RUN with STALL=0 and BUBBLE=1 this cycle; no forward occurs. Flush wins over MEM_RVALID.
    - MEM_RVALID=1 -> load_buf=MEM_RDATA, go to FWD.
    - count==TIMEOUT_CYCLES-1 -> MEM_TIMEOUT=1 (sticky until reset), go to RUN.
    - Otherwise count+1. Count saturates; no wrap.
  - FWD (exactly 1 cycle): STALL=0, BUBBLE=0.
    - RS1_OUT=load_buf if RADDR1_STAGE2==pend_rd, else RS1_IN. RS2_OUT likewise.
    - Stage 3 holds a bubble, so H cannot fire. Go to RUN.
    - If FLUSH=1 in FWD: forwarding is still applied, BUBBLE=1, go to RUN.
- Minimum load-use penalty:
  - 2 cycles (RUN-detect stall + WAIT cycle), when MEM_RVALID arrives on the first WAIT cycle.
  - Each extra memory-latency cycle adds 1.
- x0 is never a hazard source. Back-to-back dependent loads are each handled through a full RUN->WAIT->FWD sequence.
- Reset mid-WAIT/FWD: returns to RUN immediately (asynchronous). The pending forward is discarded.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants: OP_LOAD, OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_JAL, OP_STORE, OP_BRANCH.
  - Enum hz_state_t {RUN, WAIT, FWD}.
- Single module; the uses_rs1/uses_rs2 decode is a package function. No sub-module.

Test Plan:
- Load x5 in S3, add x6,x5,x7 in S2, MEM_RVALID on the next cycle with 0xDEADBEEF -> STALL/BUBBLE high 2 cycles, then FWD cycle RS1_OUT=0xDEADBEEF, RS2_OUT=RS2_IN.
- Load x0 in S3, S2 reads x0; then lw x3 in S3 with S2 = lui x3 -> no STALL in either case.
- Hazard, then MEM_RVALID delayed 5 cycles with 0x12345678 -> STALL for 6 cycles total, then one FWD cycle with RS2_OUT=0x12345678 for sw rs2 match.
- TIMEOUT_CYCLES=4, no MEM_RVALID -> STALL for 5 cycles, MEM_TIMEOUT=1 and stays 1, state returns to RUN, no forward.
- FLUSH in WAIT with MEM_RVALID the same cycle -> STALL=0 that cycle, no FWD, RS1_OUT=RS1_IN next cycle.
- Assert rst_n low during WAIT -> STALL drops asynchronously, all registers at reset values, MEM_TIMEOUT=0.
